nios_system_lcd_responder: RTL and testbench
============================================

NIOS_SYSTEM_LCD_RESPONDER -- requirements
Module: nios_system_lcd_responder

Interface
REQ-001 Parameters SHALL be: BUSY_CYC, default 2000, busy cycles per ordinary instruction or data write; CLEAR_CYC, default 82000, busy cycles for Clear Display, measured from command accept.
REQ-002 Port clk, input, 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port reset_n, input, 1: reset; asynchronous assertion, active-low.
REQ-004 Port LCD_E, input, 1: enable strobe from the bus initiator.
REQ-005 Port LCD_RS, input, 1: register select; 0 = instruction/status, 1 = data.
REQ-006 Port LCD_RW, input, 1: 1 = read, 0 = write.
REQ-007 Port LCD_data, inout, 8: bidirectional data bus.
REQ-008 Port dbg_addr, input, 7: DDRAM inspection address.
REQ-009 Port dbg_char, output, 8: DDRAM[dbg_addr], registered, 1-cycle latency.
REQ-010 Port disp_flags, output, 3: {D, C, B} from Display Control.
REQ-011 Port busy_drop, output, 1: sticky flag; set when a write arrives while busy.

Function
REQ-012 LCD_E, LCD_RS, LCD_RW and LCD_data SHALL each pass through a 2-flop synchronizer; all decode SHALL use the synchronized copies.
REQ-013 A write SHALL be accepted on a synchronized LCD_E falling edge with RW=0, using the RS and data values sampled in that same cycle.
REQ-014 LCD_data SHALL be driven only while synchronized E=1 and RW=1, and SHALL be high-Z otherwise.
REQ-015 Read response: valid data SHALL appear on LCD_data no later than 3 clk after raw LCD_E rises.
REQ-016 Status read (RS=0) SHALL return {BF, AC[6:0]}; this read is allowed while busy.
REQ-017 Data read (RS=1) SHALL return DDRAM[AC]; AC SHALL step per the I/D bit on the E falling edge.
REQ-018 Instruction decode SHALL use the highest set bit of the instruction byte:
 - 0x01: Clear Display.
 - 0x02-0x03: AC=0.
 - 0x04-0x07: I/D=bit1, S=bit0 (S stored only).
 - 0x08-0x0F: D/C/B = bits 2:0.
 - 0x10-0x1F: if bit3=0, AC steps right (bit2=1) or left (bit2=0); display shift is ignored.
 - 0x20-0x3F: function bits stored, no other effect.
 - 0x40-0x7F: CGRAM mode; data writes discarded, data reads return 0x00.
 - 0x80-0xFF: DDRAM mode, AC = data[6:0].
 - 0x00: no-op, not busy.
REQ-019 A data write (RS=1) in DDRAM mode SHALL store DDRAM[AC]=data, then step AC.
REQ-020 AC stepping SHALL wrap as follows:
 - Increment: 0x27→0x40, 0x67→0x00.
 - Decrement: 0x40→0x27, 0x00→0x67.
 - Addresses 0x28-0x3F and 0x68-0x7F SHALL be storable and SHALL step linearly.
REQ-021 The state machine SHALL have states IDLE, EXEC and CLEAR.
 - Accepted write → EXEC, with the busy counter loaded to BUSY_CYC-1.
 - 0x01 → CLEAR, which writes 0x20 to all 128 DDRAM entries at one per cycle, sets AC=0 and I/D=1, then → EXEC with the counter loaded to CLEAR_CYC-129.
 - EXEC → IDLE when the counter reaches 0.
REQ-022 BF SHALL be 1 in EXEC and CLEAR, and 0 in IDLE.
REQ-023 A write accepted while BF=1 SHALL be dropped with no state change, and SHALL set busy_drop.
REQ-024 A read while BF=1 SHALL NOT alter the busy counter; a data read while busy SHALL still step AC.
REQ-025 The dbg_char port SHALL read through a second, independent read port and SHALL NOT disturb the bus.

Reset
REQ-026 Reset assertion SHALL asynchronously force:
 - state=IDLE, BF=0, AC=0, I/D=1, S=0, {D,C,B}=0, DDRAM mode;
 - busy_drop=0, dbg_char=0x00;
 - LCD_data high-Z, synchronizers cleared.
REQ-027 DDRAM contents SHALL be undefined after reset; software issues 0x01.
REQ-028 Reset mid-CLEAR or mid-EXEC SHALL abort the operation; the first post-reset write SHALL be accepted.

Structure
REQ-029 Instruction opcode constants, the state encoding and the wrap boundaries (0x27, 0x40, 0x67) SHALL live in the shared package nios_system_lcd_pkg.
REQ-030 Synchronizer plus edge detect SHALL be one sub-module, nios_system_lcd_sync; the DDRAM SHALL be an inferred 128x8 dual-port RAM.

Verification (BUSY_CYC=8, CLEAR_CYC=200)
REQ-031 Write instr 0x80, data 0x41, 0x42, then wait 8+ cycles each → DDRAM[0]=0x41, DDRAM[1]=0x42, status read = 0x02.
REQ-032 Write 0xA7 (AC=0x27), data 0x58 → dbg_addr=0x27 returns 0x58; status = 0x40.
REQ-033 Write 0x01, poll status → BF=1 for 200 cycles, then 0x00; all dbg_char = 0x20.
REQ-034 Write 0x80, then data 0x33 within 8 cycles → data dropped, busy_drop=1, DDRAM[0] unchanged.
REQ-035 Write 0x04 (decrement), 0xC0, data 0x7E → AC=0x27, DDRAM[0x40]=0x7E.
REQ-036 Assert reset_n during CLEAR at cycle 50 → BF=0 and AC=0 immediately; a following write 0x0F sets disp_flags=3'b111.

Source files
------------

// File: rtl/nios_system_lcd_pkg.sv
// Shared constants for the HD44780-style LCD responder: opcode classes, FSM state encoding
// and DDRAM address-counter wrap points.
package nios_system_lcd_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StClear = 2'd2;

  localparam logic [6:0] AcLine0End   = 7'h27;
  localparam logic [6:0] AcLine1Start = 7'h40;
  localparam logic [6:0] AcLine1End   = 7'h67;

  localparam logic [7:0] ClearFill = 8'h20;
  localparam int unsigned DdramDepth = 128;

  typedef enum logic [3:0] {
    OpNop,
    OpClear,
    OpHome,
    OpEntry,
    OpDisplay,
    OpShift,
    OpFunc,
    OpCgram,
    OpDdram
  } lcd_op_e;

  // Instruction class is selected by the most significant set bit.
  function automatic lcd_op_e decode_op(input logic [7:0] instr);
    lcd_op_e op;
    if (instr[7])      op = OpDdram;
    else if (instr[6]) op = OpCgram;
    else if (instr[5]) op = OpFunc;
    else if (instr[4]) op = OpShift;
    else if (instr[3]) op = OpDisplay;
    else if (instr[2]) op = OpEntry;
    else if (instr[1]) op = OpHome;
    else if (instr[0]) op = OpClear;
    else               op = OpNop;
    return op;
  endfunction

  // Two-line address map: line 0 is 0x00-0x27, line 1 is 0x40-0x67; the gap steps linearly.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) begin
      if (ac == AcLine0End)      nxt = AcLine1Start;
      else if (ac == AcLine1End) nxt = 7'h00;
      else                       nxt = ac + 7'd1;
    end else begin
      if (ac == AcLine1Start)    nxt = AcLine0End;
      else if (ac == 7'h00)      nxt = AcLine1End;
      else                       nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/nios_system_lcd_sync.sv
// Two-flop synchronizer for the asynchronous LCD bus lines, plus falling-edge detect on E.
module nios_system_lcd_sync (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_e,
  input  logic       i_rs,
  input  logic       i_rw,
  input  logic [7:0] i_data,
  output logic       o_e,
  output logic       o_rs,
  output logic       o_rw,
  output logic [7:0] o_data,
  output logic       o_e_fall
);

  logic [10:0] r_meta;
  logic [10:0] r_sync;
  logic        r_e_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_e_prev <= 1'b0;
    end else begin
      r_meta   <= {i_e, i_rs, i_rw, i_data};
      r_sync   <= r_meta;
      r_e_prev <= r_sync[10];
    end
  end

  assign {o_e, o_rs, o_rw, o_data} = r_sync;
  assign o_e_fall                  = r_e_prev & ~r_sync[10];

endmodule

// File: rtl/nios_system_lcd_responder.sv
// Behavioural HD44780-style LCD controller responder: decodes bus writes, serves status and
// DDRAM reads, models busy time, and exposes a debug read port into the DDRAM.
module nios_system_lcd_responder
  import nios_system_lcd_pkg::*;
#(
  parameter int unsigned BUSY_CYC  = 2000,
  parameter int unsigned CLEAR_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  inout  wire  [7:0] LCD_data,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_char,
  output logic [2:0] disp_flags,
  output logic       busy_drop
);

  localparam int unsigned CntMax = (CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] BusyLoad  = CntW'(BUSY_CYC - 1);
  // The 128 fill cycles already count toward the Clear Display busy time.
  localparam logic [CntW-1:0] ClearLoad = CntW'(CLEAR_CYC - 129);

  logic       w_e_s;
  logic       w_rs_s;
  logic       w_rw_s;
  logic [7:0] w_data_s;
  logic       w_e_fall;

  nios_system_lcd_sync u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_e      (LCD_E),
    .i_rs     (LCD_RS),
    .i_rw     (LCD_RW),
    .i_data   (LCD_data),
    .o_e      (w_e_s),
    .o_rs     (w_rs_s),
    .o_rw     (w_rw_s),
    .o_data   (w_data_s),
    .o_e_fall (w_e_fall)
  );

  logic [1:0]      r_state;
  logic [CntW-1:0] r_cnt;
  logic [6:0]      r_ac;
  logic            r_id;
  logic            r_s;
  logic [2:0]      r_dcb;
  logic [2:0]      r_func;
  logic            r_cgram;
  logic [6:0]      r_clr_idx;

  logic [1:0]      w_state_nxt;
  logic [CntW-1:0] w_cnt_nxt;
  logic [6:0]      w_ac_nxt;
  logic            w_id_nxt;
  logic            w_s_nxt;
  logic [2:0]      w_dcb_nxt;
  logic [2:0]      w_func_nxt;
  logic            w_cgram_nxt;
  logic            w_drop_nxt;
  logic [6:0]      w_clr_idx_nxt;

  logic            w_ram_we;
  logic [6:0]      w_addr_a;
  logic [7:0]      w_ram_wdata;
  lcd_op_e         w_op;
  logic            w_bf;
  logic            w_wr_acc;
  logic            w_data_rd;

  assign w_bf      = (r_state != StIdle);
  assign w_op      = decode_op(w_data_s);
  assign w_wr_acc  = w_e_fall & ~w_rw_s;
  assign w_data_rd = w_e_fall & w_rw_s & w_rs_s;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ac_nxt      = r_ac;
    w_id_nxt      = r_id;
    w_s_nxt       = r_s;
    w_dcb_nxt     = r_dcb;
    w_func_nxt    = r_func;
    w_cgram_nxt   = r_cgram;
    w_drop_nxt    = busy_drop;
    w_clr_idx_nxt = r_clr_idx;
    w_ram_we      = 1'b0;
    w_addr_a      = r_ac;
    w_ram_wdata   = w_data_s;

    // Data reads advance AC even while busy.
    if (w_data_rd) begin
      w_ac_nxt = ac_step(r_ac, r_id);
    end

    case (r_state)
      StExec: begin
        if (r_cnt == '0) w_state_nxt = StIdle;
        else             w_cnt_nxt   = r_cnt - CntW'(1);
      end
      StClear: begin
        w_ram_we      = 1'b1;
        w_addr_a      = r_clr_idx;
        w_ram_wdata   = ClearFill;
        w_clr_idx_nxt = r_clr_idx + 7'd1;
        if (r_clr_idx == 7'h7f) begin
          w_ac_nxt    = 7'h00;
          w_id_nxt    = 1'b1;
          w_state_nxt = StExec;
          w_cnt_nxt   = ClearLoad;
        end
      end
      default: ;
    endcase

    if (w_wr_acc) begin
      if (w_bf) begin
        w_drop_nxt = 1'b1;
      end else if (w_rs_s) begin
        w_state_nxt = StExec;
        w_cnt_nxt   = BusyLoad;
        if (!r_cgram) begin
          w_ram_we = 1'b1;
          w_ac_nxt = ac_step(r_ac, r_id);
        end
      end else begin
        if (w_op != OpNop) begin
          w_state_nxt = StExec;
          w_cnt_nxt   = BusyLoad;
        end
        unique case (w_op)
          OpClear: begin
            w_state_nxt   = StClear;
            w_clr_idx_nxt = 7'h00;
          end
          OpHome:    w_ac_nxt = 7'h00;
          OpEntry: begin
            w_id_nxt = w_data_s[1];
            w_s_nxt  = w_data_s[0];
          end
          OpDisplay: w_dcb_nxt = w_data_s[2:0];
          OpShift: begin
            if (!w_data_s[3]) w_ac_nxt = ac_step(r_ac, w_data_s[2]);
          end
          OpFunc:    w_func_nxt = w_data_s[4:2];
          OpCgram:   w_cgram_nxt = 1'b1;
          OpDdram: begin
            w_cgram_nxt = 1'b0;
            w_ac_nxt    = w_data_s[6:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_ac      <= 7'h00;
      r_id      <= 1'b1;
      r_s       <= 1'b0;
      r_dcb     <= 3'b000;
      r_func    <= 3'b000;
      r_cgram   <= 1'b0;
      r_clr_idx <= 7'h00;
      busy_drop <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ac      <= w_ac_nxt;
      r_id      <= w_id_nxt;
      r_s       <= w_s_nxt;
      r_dcb     <= w_dcb_nxt;
      r_func    <= w_func_nxt;
      r_cgram   <= w_cgram_nxt;
      r_clr_idx <= w_clr_idx_nxt;
      busy_drop <= w_drop_nxt;
    end
  end

  assign disp_flags = r_dcb;

  // DDRAM: port A is the bus side (write + continuous read at AC), port B the debug read.
  logic [7:0] r_ram [DdramDepth];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_addr_a] <= w_ram_wdata;
    r_rd_data <= r_ram[w_addr_a];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dbg_char <= 8'h00;
    else          dbg_char <= r_ram[dbg_addr];
  end

  logic       w_oe;
  logic [7:0] w_rd_out;

  assign w_oe     = w_e_s & w_rw_s;
  assign w_rd_out = w_rs_s ? (r_cgram ? 8'h00 : r_rd_data) : {w_bf, r_ac};
  assign LCD_data = w_oe ? w_rd_out : 8'hzz;

endmodule

// File: tb/tb_nios_system_lcd_responder.sv
// Scoreboard bench for the LCD responder: stimulus queues expected values, a monitor process
// compares them against observations published by the bus/debug access tasks.
module tb_nios_system_lcd_responder;

  localparam int unsigned BusyCyc  = 8;
  localparam int unsigned ClearCyc = 200;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [7:0] tb_d = 8'h00;
  logic       tb_oe = 1'b0;
  wire  [7:0] lcd_data;
  logic [6:0] dbg_addr = 7'h00;
  logic [7:0] dbg_char;
  logic [2:0] disp_flags;
  logic       busy_drop;

  assign lcd_data = tb_oe ? tb_d : 8'hzz;

  nios_system_lcd_responder #(
    .BUSY_CYC  (BusyCyc),
    .CLEAR_CYC (ClearCyc)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .LCD_E      (lcd_e),
    .LCD_RS     (lcd_rs),
    .LCD_RW     (lcd_rw),
    .LCD_data   (lcd_data),
    .dbg_addr   (dbg_addr),
    .dbg_char   (dbg_char),
    .disp_flags (disp_flags),
    .busy_drop  (busy_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad = 0;
  logic  obs_valid = 1'b0;
  int    obs_val = 0;
  int    fall_cyc = 0;

  // Monitor: one comparison per published observation.
  initial begin
    int    e;
    string n;
    forever begin
      @(posedge clk);
      if (obs_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_obs: got 0x%0h, required no observation", obs_val);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (obs_val !== e) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", n, obs_val, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input string name, input int val);
    exp_q.push_back(val);
    name_q.push_back(name);
  endtask

  task automatic observe(input int val);
    obs_val   = val;
    obs_valid = 1'b1;
    @(posedge clk);
    #1 obs_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] data);
    lcd_rs = rs;
    lcd_rw = 1'b0;
    tb_d   = data;
    tb_oe  = 1'b1;
    lcd_e  = 1'b1;
    repeat (2) @(negedge clk);
    lcd_e    = 1'b0;
    fall_cyc = cyc;
    repeat (2) @(negedge clk);
    tb_oe = 1'b0;
  endtask

  task automatic write_wait(input logic rs, input logic [7:0] data);
    bus_write(rs, data);
    repeat (12) @(negedge clk);
  endtask

  // Samples exactly 3 clocks after the raw E rise.
  task automatic bus_read(input logic rs, output int val);
    lcd_rs = rs;
    lcd_rw = 1'b1;
    lcd_e  = 1'b1;
    repeat (3) @(negedge clk);
    val   = int'(lcd_data);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic check_read(input string name, input logic rs, input int expv);
    int v;
    push_exp(name, expv);
    bus_read(rs, v);
    observe(v);
  endtask

  task automatic check_dbg(input string name, input logic [6:0] addr, input int expv);
    push_exp(name, expv);
    dbg_addr = addr;
    @(posedge clk);
    @(negedge clk);
    observe(int'(dbg_char));
  endtask

  task automatic check_val(input string name, input int actual, input int expv);
    push_exp(name, expv);
    observe(actual);
  endtask

  initial begin
    int first_v;
    int end_v;
    int end_cyc;
    int t_fall;
    bit got;
    string n;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_dbg_char", int'(dbg_char), 'h00);
    check_val("rst_disp_flags", int'(disp_flags), 0);
    check_val("rst_busy_drop", int'(busy_drop), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_read("rst_status", 1'b0, 'h00);

    // Basic DDRAM writes and reads
    write_wait(1'b0, 8'h80);
    write_wait(1'b1, 8'h41);
    write_wait(1'b1, 8'h42);
    check_dbg("ddram0", 7'h00, 'h41);
    check_dbg("ddram1", 7'h01, 'h42);
    check_read("status_ac2", 1'b0, 'h02);
    write_wait(1'b0, 8'h80);
    check_read("data_rd0", 1'b1, 'h41);
    check_read("data_rd1", 1'b1, 'h42);
    check_read("status_after_rd", 1'b0, 'h02);

    // Line-0 end wraps to line-1 start
    write_wait(1'b0, 8'hA7);
    write_wait(1'b1, 8'h58);
    check_dbg("ddram27", 7'h27, 'h58);
    check_read("status_wrap_inc", 1'b0, 'h40);

    // Cursor shifts move AC across the wrap points
    write_wait(1'b0, 8'h10);
    check_read("shift_left", 1'b0, 'h27);
    write_wait(1'b0, 8'h14);
    check_read("shift_right", 1'b0, 'h40);
    write_wait(1'b0, 8'hE7);
    write_wait(1'b0, 8'h14);
    check_read("shift_wrap67", 1'b0, 'h00);
    write_wait(1'b0, 8'hC0);

    // Clear Display: busy for ClearCyc cycles from accept (accept is 3 clocks after raw fall)
    push_exp("clear_first_status", 'hC0);
    push_exp("clear_busy_len", 3 + ClearCyc);
    push_exp("clear_end_status", 'h00);
    bus_write(1'b0, 8'h01);
    t_fall  = fall_cyc;
    lcd_rs  = 1'b0;
    lcd_rw  = 1'b1;
    lcd_e   = 1'b1;
    repeat (3) @(negedge clk);
    first_v = int'(lcd_data);
    got     = 1'b0;
    end_v   = -1;
    end_cyc = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (!lcd_data[7]) begin
        got     = 1'b1;
        end_cyc = cyc;
        end_v   = int'(lcd_data);
      end else begin
        @(negedge clk);
      end
    end
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
    lcd_rw = 1'b0;
    observe(first_v);
    observe(got ? end_cyc - t_fall : -1);
    observe(end_v);
    for (int a = 0; a < 128; a++) begin
      check_dbg($sformatf("clear_fill_%0h", a), 7'(a), 'h20);
    end

    // Write while busy is dropped
    bus_write(1'b0, 8'h80);
    bus_write(1'b1, 8'h33);
    repeat (12) @(negedge clk);
    check_val("busy_drop_set", int'(busy_drop), 1);
    check_dbg("drop_ddram0", 7'h00, 'h20);
    check_read("drop_status", 1'b0, 'h00);

    // Decrement mode and its wrap points
    write_wait(1'b0, 8'h04);
    write_wait(1'b0, 8'hC0);
    write_wait(1'b1, 8'h7E);
    check_read("status_wrap_dec", 1'b0, 'h27);
    check_dbg("ddram40", 7'h40, 'h7E);
    write_wait(1'b0, 8'h80);
    write_wait(1'b1, 8'h11);
    check_read("status_wrap_dec0", 1'b0, 'h67);
    check_dbg("ddram0_dec", 7'h00, 'h11);

    // CGRAM mode: writes discarded, reads return zero
    write_wait(1'b0, 8'h40);
    write_wait(1'b1, 8'h99);
    check_read("cgram_rd", 1'b1, 'h00);
    write_wait(1'b0, 8'h80);
    check_dbg("cgram_no_store", 7'h67, 'h20);

    // Display control and no-op
    write_wait(1'b0, 8'h0D);
    check_val("disp_flags_5", int'(disp_flags), 5);
    bus_write(1'b0, 8'h00);
    check_read("nop_not_busy", 1'b0, 'h00);

    // Reset in the middle of CLEAR
    write_wait(1'b0, 8'hC5);
    bus_write(1'b0, 8'h01);
    repeat (48) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_val("midrst_busy_drop", int'(busy_drop), 0);
    check_val("midrst_disp_flags", int'(disp_flags), 0);
    check_val("midrst_dbg_char", int'(dbg_char), 'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_read("midrst_status", 1'b0, 'h00);
    write_wait(1'b0, 8'h0F);
    check_val("post_rst_disp", int'(disp_flags), 7);

    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      n = name_q.pop_front();
      void'(exp_q.pop_front());
      total++;
      bad++;
      $display("FAIL %s: got no observation, required one", n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
